multi_phase_signal_ctrl: RTL and testbench
==========================================

// Module: multi_phase_signal_ctrl
// PURPOSE
//  Parametrised N-phase intersection signal controller, successor to the fixed 2-direction controller.
//  Actuated sequencing with min/max green, yellow and all-red clearance, latched pedestrian calls,
//  and emergency preemption with a defined exit. Sits between sensor/request sync logic and lamp drivers.
// PARAMETERS
//  NUM_PHASES  4   number of mutually exclusive phases (2..8)
//  TMR_W       6   timer/counter width; every duration must be < 2**TMR_W
//  GREEN_MIN   8   minimum green cycles (must be >= WALK_T)
//  GREEN_MAX   20  max green cycles once a conflicting call exists
//  YELLOW_T    3   yellow cycles (never truncated)
//  ALLRED_T    2   all-red clearance cycles
//  WALK_T      5   walk cycles at start of green
// PORTS
//  clk             in   1              clock
//  rst_n           in   1              synchronous, active-low reset
//  demand          in   NUM_PHASES     vehicle call per phase, level
//  ped_req         in   NUM_PHASES     pedestrian button per phase, pulse, latched internally
//  preempt         in   1              emergency preemption request, level
//  preempt_phase   in   $clog2(NUM_PHASES)  phase to serve during preemption
//  lamps           out  3*NUM_PHASES   per phase {R,Y,G}, phase p at [3p+2:3p]
//  walk            out  NUM_PHASES     walk indication per phase
//  active_phase    out  $clog2(NUM_PHASES)  phase currently green/yellow
//  preempt_active  out  1              high in PRE_HOLD
//  fault           out  1              conflict monitor trip (0 when monitor compiled out)
// BEHAVIOUR
//  - All outputs registered, updated on the same edge as the state register.
//  - Reset: state ALL_RED, timer=ALLRED_T-1, lamps all 3'b100, walk=0, active_phase=0,
//    preempt_active=0, fault=0, ped latches cleared. Reset mid-cycle aborts any phase immediately.
//  - Timer: down-counter loaded with D-1 on state entry; done at 0, so a state lasts exactly D cycles.
//  - Elapsed: saturating up-counter cleared on GREEN entry.
//  - States: GREEN -> YELLOW -> ALL_RED -> GREEN(next); PRE_HOLD.
//  - GREEN: leave when elapsed>=GREEN_MIN and any other phase is called (demand|ped latch)
//    and (own demand low or elapsed>=GREEN_MAX). With no other call, rest in green indefinitely.
//  - Next phase: first called phase scanning active_phase+1 upward, wrapping modulo NUM_PHASES.
//    The search is taken at ALL_RED exit. If no call exists then, re-serve active_phase.
//  - Ped latch: set on ped_req[p], cleared on GREEN entry of p. ped_req for the current green phase
//    is latched for the next service, not honoured mid-green. walk[p]=1 for first WALK_T cycles
//    of green only if latch was set at entry.
//  - Preempt, sampled every cycle:
//    - GREEN of preempt_phase: go PRE_HOLD.
//    - GREEN of another phase: YELLOW immediately, ignoring GREEN_MIN.
//    - YELLOW/ALL_RED: complete the state. ALL_RED exit forces next phase=preempt_phase and enters PRE_HOLD.
//    - Walk drops to 0 on the cycle preempt is seen.
//  - PRE_HOLD: preempt_phase green, preempt_active=1. Exit on preempt low to GREEN with elapsed
//    continuing, so normal rules resume. A preempt_phase change while in PRE_HOLD triggers YELLOW.
//  - Invariant: at most one phase non-red; yellow always followed by ALL_RED.
// CONFIGURATION
//  SIGNAL_CONFLICT_MONITOR_EN defined:
//    - Instantiates monitor on lamps; if more than one phase is non-red, fault=1 on the next edge.
//    - All lamps forced 3'b100 and walk=0 until rst_n.
//  Undefined: fault tied 0, no monitor logic.
// STRUCTURE
//  signal_ctrl_pkg:
//    - state_t enum {GREEN, YELLOW, ALL_RED, PRE_HOLD}
//    - lamp constants LAMP_RED/YELLOW/GREEN
//  Sub-module: signal_conflict_monitor (under the macro). Next-phase search is a function in the package.
// TESTING  (defaults)
//  1 reset, demand=0 -> lamps all red 2 cycles, phase0 green on 3rd cycle, rests green.
//  2 demand=4'b0100 at phase0 green entry -> green 8, yellow 3, all-red 2, phase2 green (phase1 skipped).
//  3 demand=4'b0011 held -> phase0 max-out at 20 cycles green, then serves phase1.
//  4 ped_req[1] pulse during phase0 green, demand=0 -> phase1 green after clearance, walk[1]=1 exactly 5 cycles.
//  5 preempt=1, preempt_phase=3 on phase0 yellow cycle 1 -> yellow 3 total, all-red 2, phase3 green,
//    preempt_active=1. Drop preempt -> preempt_active=0 next cycle.
//  6 macro on, force phases 0 and 1 green -> fault=1 next cycle, all red; held until rst_n low.

Source files
------------

// File: rtl/signal_ctrl_pkg.sv
// rtl/signal_ctrl_pkg.sv - shared types, lamp encodings and next-phase search for the signal controller
package signal_ctrl_pkg;

  typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED, PRE_HOLD} state_t;

  // Lamp field layout is {R,Y,G}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int MAX_PHASES = 8;

  // First called phase after cur, wrapping; cur itself is the last candidate and the fallback.
  function automatic logic [2:0] next_phase(input logic [7:0] calls, input logic [2:0] cur, input int n);
    logic [2:0] sel;
    int idx;
    sel = cur;
    for (int k = MAX_PHASES; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(cur) + k) % n;
        if (calls[idx[2:0]]) sel = idx[2:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/signal_conflict_monitor.sv
// rtl/signal_conflict_monitor.sv - flags more than one non-red phase; fault is sticky until reset
module signal_conflict_monitor import signal_ctrl_pkg::*; #(
  parameter int NUM_PHASES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3*NUM_PHASES-1:0] lamps,
  output logic                    conflict,
  output logic                    fault
);

  int n_lit;

  always_comb begin
    n_lit = 0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (lamps[3*p +: 3] != LAMP_RED) n_lit = n_lit + 1;
    end
    conflict = (n_lit > 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fault <= 1'b0;
    else        fault <= fault | conflict;
  end

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// rtl/multi_phase_signal_ctrl.sv - N-phase actuated signal controller with ped latches and preemption
// Optional conflict monitor: SIGNAL_CONFLICT_MONITOR_EN
module multi_phase_signal_ctrl import signal_ctrl_pkg::*; #(
  parameter int NUM_PHASES = 4,
  parameter int TMR_W      = 6,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int WALK_T     = 5,
  localparam int PW        = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PHASES-1:0]   demand,
  input  logic [NUM_PHASES-1:0]   ped_req,
  input  logic                    preempt,
  input  logic [PW-1:0]           preempt_phase,
  output logic [3*NUM_PHASES-1:0] lamps,
  output logic [NUM_PHASES-1:0]   walk,
  output logic [PW-1:0]           active_phase,
  output logic                    preempt_active,
  output logic                    fault
);

  localparam logic [TMR_W-1:0] Y_LOAD  = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] AR_LOAD = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W:0]   G_MIN   = (TMR_W+1)'(GREEN_MIN);
  localparam logic [TMR_W:0]   G_MAX   = (TMR_W+1)'(GREEN_MAX);
  localparam logic [TMR_W:0]   W_LEN   = (TMR_W+1)'(WALK_T);

  state_t                  state, state_nxt;
  logic [TMR_W-1:0]        timer, timer_nxt, elapsed, elapsed_nxt;
  logic [TMR_W:0]          served;
  logic [PW-1:0]           active_nxt;
  logic [NUM_PHASES-1:0]   ped_lat, ped_lat_nxt, calls, other, walk_nxt, clr_mask;
  logic [3*NUM_PHASES-1:0] lamps_nxt;
  logic                    enter_green, trip;

  // served counts the current cycle too, so a decision here ends green after exactly `served` cycles
  assign served = {1'b0, elapsed} + 1'b1;
  assign calls  = demand | ped_lat;
  assign other  = calls & ~(NUM_PHASES'(1) << active_phase);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    elapsed_nxt = elapsed;
    active_nxt  = active_phase;
    walk_nxt    = '0;
    enter_green = 1'b0;
    if (timer != '0)   timer_nxt   = timer - 1'b1;
    if (elapsed != '1) elapsed_nxt = elapsed + 1'b1;
    case (state)
      GREEN: begin
        if (preempt) begin
          if (preempt_phase == active_phase) begin
            state_nxt = PRE_HOLD;
          end else begin
            state_nxt = YELLOW;
            timer_nxt = Y_LOAD;
          end
        end else if (served >= G_MIN && |other && (!demand[active_phase] || served >= G_MAX)) begin
          state_nxt = YELLOW;
          timer_nxt = Y_LOAD;
        end else begin
          walk_nxt = walk & {NUM_PHASES{served < W_LEN}};
        end
      end
      YELLOW: begin
        if (timer == '0) begin
          state_nxt = ALL_RED;
          timer_nxt = AR_LOAD;
        end
      end
      ALL_RED: begin
        if (timer == '0) begin
          elapsed_nxt = '0;
          if (preempt) begin
            active_nxt = preempt_phase;
            state_nxt  = PRE_HOLD;
          end else begin
            active_nxt  = PW'(next_phase(8'(calls), 3'(active_phase), NUM_PHASES));
            state_nxt   = GREEN;
            enter_green = 1'b1;
            walk_nxt    = (NUM_PHASES'(1) << active_nxt) & ped_lat;
          end
        end
      end
      PRE_HOLD: begin
        if (!preempt) begin
          state_nxt = GREEN;
        end else if (preempt_phase != active_phase) begin
          state_nxt = YELLOW;
          timer_nxt = Y_LOAD;
        end
      end
      default: state_nxt = ALL_RED;
    endcase
    clr_mask    = enter_green ? (NUM_PHASES'(1) << active_nxt) : '0;
    ped_lat_nxt = (ped_lat & ~clr_mask) | ped_req;
  end

`ifdef SIGNAL_CONFLICT_MONITOR_EN
  logic mon_conflict, mon_fault;

  signal_conflict_monitor #(.NUM_PHASES(NUM_PHASES)) u_monitor (
    .clk      (clk),
    .rst_n    (rst_n),
    .lamps    (lamps),
    .conflict (mon_conflict),
    .fault    (mon_fault)
  );

  assign trip  = mon_conflict | mon_fault;
  assign fault = mon_fault;
`else
  assign trip  = 1'b0;
  assign fault = 1'b0;
`endif

  always_comb begin
    lamps_nxt = {NUM_PHASES{LAMP_RED}};
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (!trip && PW'(p) == active_nxt) begin
        if (state_nxt == GREEN || state_nxt == PRE_HOLD) lamps_nxt[3*p +: 3] = LAMP_GREEN;
        else if (state_nxt == YELLOW)                     lamps_nxt[3*p +: 3] = LAMP_YELLOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ALL_RED;
      timer          <= AR_LOAD;
      elapsed        <= '0;
      active_phase   <= '0;
      ped_lat        <= '0;
      lamps          <= {NUM_PHASES{LAMP_RED}};
      walk           <= '0;
      preempt_active <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      elapsed        <= elapsed_nxt;
      active_phase   <= active_nxt;
      ped_lat        <= ped_lat_nxt;
      lamps          <= lamps_nxt;
      walk           <= trip ? '0 : walk_nxt;
      preempt_active <= (state_nxt == PRE_HOLD);
    end
  end

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// tb/tb_multi_phase_signal_ctrl.sv - scoreboard bench: behavioural phase model vs. multi_phase_signal_ctrl
module tb_multi_phase_signal_ctrl;

  localparam int NP    = 4;
  localparam int PWB   = 2;
  localparam int G_MIN = 8;
  localparam int G_MAX = 20;
  localparam int Y_T   = 3;
  localparam int AR_T  = 2;
  localparam int W_T   = 5;

  localparam int M_GREEN = 0, M_YELLOW = 1, M_CLEAR = 2, M_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     demand = '0;
  logic [NP-1:0]     ped_req = '0;
  logic              preempt = 1'b0;
  logic [PWB-1:0]    preempt_phase = '0;
  logic [3*NP-1:0]   lamps;
  logic [NP-1:0]     walk;
  logic [PWB-1:0]    active_phase;
  logic              preempt_active;
  logic              fault;

  multi_phase_signal_ctrl #(
    .NUM_PHASES(NP), .TMR_W(6), .GREEN_MIN(G_MIN), .GREEN_MAX(G_MAX),
    .YELLOW_T(Y_T), .ALLRED_T(AR_T), .WALK_T(W_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .demand(demand), .ped_req(ped_req),
    .preempt(preempt), .preempt_phase(preempt_phase), .lamps(lamps), .walk(walk),
    .active_phase(active_phase), .preempt_active(preempt_active), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [3*NP-1:0] lamps;
    logic [NP-1:0]   walk;
    logic [PWB-1:0]  ap;
    logic            pa;
    logic            flt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the intersection is showing, in cycles remaining / cycles served
  int            m_mode = M_CLEAR;
  int            m_left = AR_T;
  int            m_served = 0;
  int            m_walk = 0;
  int            m_phase = 0;
  logic [NP-1:0] m_ped = '0;

  task automatic model_step(input logic [NP-1:0] dem, input logic [NP-1:0] ped,
                            input logic pre, input int pp, input logic rn);
    logic [NP-1:0] calls, old_ped;
    logic          other;
    int            nxt;
    if (!rn) begin
      m_mode = M_CLEAR; m_left = AR_T; m_phase = 0; m_ped = '0; m_walk = 0; m_served = 0;
      return;
    end
    old_ped = m_ped;
    calls   = dem | m_ped;
    other   = 1'b0;
    for (int p = 0; p < NP; p++) if (p != m_phase && calls[p]) other = 1'b1;
    m_ped = m_ped | ped;
    case (m_mode)
      M_GREEN: begin
        if (pre) begin
          m_walk = 0;
          if (pp == m_phase) begin m_mode = M_HOLD; m_served++; end
          else begin m_mode = M_YELLOW; m_left = Y_T; end
        end else if (m_served >= G_MIN && other && (!dem[m_phase] || m_served >= G_MAX)) begin
          m_mode = M_YELLOW; m_left = Y_T; m_walk = 0;
        end else begin
          m_served++;
          if (m_walk > 0) m_walk--;
        end
      end
      M_YELLOW: begin
        if (m_left > 1) m_left--;
        else begin m_mode = M_CLEAR; m_left = AR_T; end
      end
      M_CLEAR: begin
        if (m_left > 1) m_left--;
        else begin
          m_served = 1;
          if (pre) begin
            m_phase = pp; m_mode = M_HOLD;
          end else begin
            nxt = m_phase;
            for (int k = 1; k <= NP; k++) begin
              if (calls[(m_phase + k) % NP]) begin nxt = (m_phase + k) % NP; break; end
            end
            m_phase = nxt;
            m_mode  = M_GREEN;
            m_walk  = old_ped[nxt] ? W_T : 0;
            m_ped[nxt] = ped[nxt];
          end
        end
      end
      default: begin
        if (!pre) begin m_mode = M_GREEN; m_served++; end
        else if (pp != m_phase) begin m_mode = M_YELLOW; m_left = Y_T; end
        else m_served++;
      end
    endcase
  endtask

  task automatic step(input logic [NP-1:0] dem, input logic [NP-1:0] ped,
                      input logic pre, input logic [PWB-1:0] pp, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    demand = dem; ped_req = ped; preempt = pre; preempt_phase = pp; rst_n = rn;
    model_step(dem, ped, pre, int'(pp), rn);
    e.cyc   = cyc + 1;
    e.lamps = '0;
    for (int p = 0; p < NP; p++) begin
      e.lamps[3*p +: 3] = 3'b100;
      if (p == m_phase && (m_mode == M_GREEN || m_mode == M_HOLD)) e.lamps[3*p +: 3] = 3'b001;
      if (p == m_phase && m_mode == M_YELLOW)                      e.lamps[3*p +: 3] = 3'b010;
    end
    e.walk = (m_mode == M_GREEN && m_walk > 0) ? NP'(1) << m_phase : '0;
    e.ap   = PWB'(m_phase);
    e.pa   = (m_mode == M_HOLD);
    e.flt  = 1'b0;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if ({lamps, walk, active_phase, preempt_active, fault} !== {e.lamps, e.walk, e.ap, e.pa, e.flt}) begin
        errors++;
        if (errors <= 30)
          $display("FAIL outputs cyc %0d got lamps=%h walk=%b ap=%0d pa=%b fault=%b expected lamps=%h walk=%b ap=%0d pa=%b fault=%b",
                   cyc, lamps, walk, active_phase, preempt_active, fault, e.lamps, e.walk, e.ap, e.pa, e.flt);
      end
    end
  end

  task automatic idle(input int n, input logic [NP-1:0] dem);
    for (int i = 0; i < n; i++) step(dem, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step('0, '0, 1'b0, '0, 1'b0);
  endtask

  logic [NP-1:0]  r_dem;
  logic [NP-1:0]  r_ped;
  logic           r_pre;
  logic [PWB-1:0] r_pp;
  logic           r_rn;

  initial begin
    do_reset();
    idle(12, '0);
    do_reset();
    idle(3, '0);
    idle(30, 4'b0100);
    do_reset();
    idle(60, 4'b0011);
    do_reset();
    idle(4, '0);
    step('0, 4'b0010, 1'b0, '0, 1'b1);
    idle(30, '0);
    do_reset();
    idle(3, '0);
    idle(8, 4'b0010);
    for (int i = 0; i < 15; i++) step(4'b0010, '0, 1'b1, 2'd3, 1'b1);
    idle(10, '0);
    r_dem = '0; r_pre = 1'b0; r_pp = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  r_dem = NP'($urandom) & NP'($urandom);
      r_ped = ($urandom_range(15) == 0) ? NP'($urandom) : '0;
      if ($urandom_range(39) == 0) r_pre = ~r_pre;
      if ($urandom_range(59) == 0) r_pp = PWB'($urandom);
      r_rn = ($urandom_range(499) != 0);
      step(r_dem, r_ped, r_pre, r_pp, r_rn);
    end
    idle(2, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
`ifdef SIGNAL_CONFLICT_MONITOR_EN
    @(posedge clk); #1;
    force dut.lamps = {3'b100, 3'b100, 3'b001, 3'b001};
    @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL monitor_trip got fault=%b expected 1", fault); end
    release dut.lamps;
    repeat (3) @(negedge clk);
    checks++;
    if ({lamps, walk, fault} !== {{NP{3'b100}}, {NP{1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL monitor_hold got lamps=%h walk=%b fault=%b expected all red, walk 0, fault 1", lamps, walk, fault);
    end
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL monitor_reset got fault=%b expected 0", fault); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
